spi_master_driver: RTL and testbench
====================================

# spi_master_driver

Byte-level SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that generates `sclk`, `cs` and `mosi` and captures `miso`. It is the initiator counterpart to `spi_slave_driver` and is the shift engine for the upcoming master-side SPI processing unit. Word assembly and NITTA buffering stay in the PU; this block moves exactly one `DATA_WIDTH` frame per accepted `start`.

## Interface
- `DATA_WIDTH`, 8: bits per frame; must be ≥1.
- `SCLK_HALFPERIOD`, 4: `clk` cycles per `sclk` half-period (H); must be ≥1. Use ≥4 when driving a `spi_slave_driver` clocked by the same `clk`.

- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a frame; accepted only when `ready`=1.
- `data_in` input DATA_WIDTH: frame to transmit; sampled only on the accepting edge.
- `data_out` output DATA_WIDTH: last received frame; held until the next `done`.
- `ready` output 1: idle and able to accept `start`.
- `done` output 1: one-cycle pulse when `data_out` is updated.
- `mosi` output 1: serial data to the slave.
- `miso` input 1: serial data from the slave.
- `sclk` output 1: SPI clock; idles low.
- `cs` output 1: chip select, active low.

## Operation
- Reset values, applied asynchronously: `cs`=1, `sclk`=0, `mosi`=0, `ready`=1, `done`=0, `data_out`=0, FSM=IDLE, counters=0.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE: `ready`=1. On `start`=1, latch `data_in` into the tx shifter, set `cs`<=0 and `mosi`<=`data_in[DATA_WIDTH-1]`, set `ready`<=0, clear the bit counter, go to SETUP.
- SETUP: wait H cycles with `cs` low and `sclk` low, then set `sclk`<=1, shift `miso` into the rx LSB, go to HIGH.
- HIGH: wait H cycles, then set `sclk`<=0.
  - If the bit counter is DATA_WIDTH-1, go to HOLD.
  - Otherwise shift tx left, put the next bit on `mosi`, increment the bit counter, go to LOW.
- LOW: wait H cycles, then set `sclk`<=1, sample `miso` into rx, go to HIGH.
- HOLD: wait H cycles, then set `cs`<=1, `data_out`<=rx, `done`<=1 for one cycle, `mosi`<=0, go to GAP.
- GAP: wait H cycles with `cs` high, then set `ready`<=1, go to IDLE.
- Received bits are MSB first. The first sampled bit ends up in `data_out[DATA_WIDTH-1]`.
- `start` while `ready`=0 is ignored, with no queuing.
- If `start` is held high, frames run back to back, each separated by the GAP.
- `data_in` changes after acceptance have no effect on the frame in flight.
- `rst` mid-frame aborts at once: `cs` rises, `sclk` and `mosi` drop, and no `done` is produced.
- `miso` is used unsynchronised. The slave must drive it in the same `clk` domain, or the board-level path must meet half-period setup.
- Counters are sized `$clog2` of their limit plus 1. No wrap occurs within a frame.

## Timing
- T0 is the edge that accepts `start`.
- `cs` falls at T0.
- Rising `sclk` edge k (k=0..D-1, D=DATA_WIDTH) occurs at T0+H+2Hk; `miso` is sampled on that same edge.
- Falling edge k occurs at T0+2H+2Hk, and `mosi` changes on it, except after the last bit.
- `cs` rises, `data_out` updates and `done`=1 at T0+2HD+H. `done` drops on the next edge.
- `ready` returns at T0+2HD+2H. The earliest next acceptance is that same edge if `start`=1.
- Example, H=1 and D=8: `cs` low at T0..T0+16, `done` at T0+17, `ready` at T0+18.
- `sclk` has exactly D rising edges per frame, with a 50% duty cycle.

## Test plan
- Loopback (`miso` tied to `mosi`), H=1, D=8, `data_in`=0xA5, single `start` pulse:
  - `data_out`=0xA5 and `done` at T0+17, `ready` at T0+18.
  - Exactly 8 `sclk` rises, and the `mosi` pattern is 1,0,1,0,0,1,0,1.
- Slave model drives 0x3C on `miso` while the master sends 0xFF, H=4:
  - `data_out`=0x3C at T0+68.
  - `mosi` is constant 1 while `cs` is low.
- `start` held high with `data_in` toggling 0x01/0x80, H=2:
  - Two frames, each carrying the value present at its own acceptance edge.
  - `cs` high for exactly 2 cycles between frames.
- `start` pulsed at T0+3 during a frame: ignored, with no second frame and `ready` still 0.
- `rst` asserted at T0+5, asynchronously mid-clock:
  - Outputs go to reset values before the next `clk` edge; no `done`; `data_out` stays 0.
  - A new frame after release completes normally.
- Connect to `spi_slave_driver` on the same `clk`, H=4, D=8: bytes 0x5A master->slave and 0xC3 slave->master both arrive intact.

Source files
------------

// File: rtl/spi_master_driver_if.sv
// spi_master_driver_if: control and serial pins of the byte-level SPI master.
// master modport faces the shift engine, slave modport faces its user.
interface spi_master_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  logic                  done;
  logic                  mosi;
  logic                  miso;
  logic                  sclk;
  logic                  cs;

  modport master (
    input  start,
    input  data_in,
    input  miso,
    output data_out,
    output ready,
    output done,
    output mosi,
    output sclk,
    output cs
  );

  modport slave (
    output start,
    output data_in,
    output miso,
    input  data_out,
    input  ready,
    input  done,
    input  mosi,
    input  sclk,
    input  cs
  );
endinterface

// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI mode 0 master, MSB first, one frame per start.
// Every pin is registered; miso is sampled on the sclk rising edge.
module spi_master_driver #(
  parameter int DATA_WIDTH      = 8,
  parameter int SCLK_HALFPERIOD = 4
) (
  input logic                 clk,
  input logic                 rst,
  spi_master_driver_if.master bus
);

  localparam int HW = $clog2(SCLK_HALFPERIOD) + 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(SCLK_HALFPERIOD - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_e;

  state_e                state_q, state_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic                  half_end;
  logic                  accept;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH:0]   rx_ext;

  assign half_end = (hcnt_q == H_LAST);
  assign tx_sh    = tx_q << 1;
  assign rx_ext   = {rx_q, bus.miso};

  assign bus.cs       = cs_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.data_out = dout_q;

  // State, counters, shifters and pin registers; reset drops the frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state and pin logic; each non-idle state lasts one sclk half-period.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    accept  = 1'b0;

    if (state_q != IDLE) begin
      hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        accept = bus.start;
      end
      SETUP, LOW: begin
        if (half_end) begin
          sclk_d  = 1'b1;
          rx_d    = rx_ext[DATA_WIDTH-1:0];
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (half_end) begin
          sclk_d = 1'b0;
          if (bit_q == B_LAST) begin
            state_d = HOLD;
          end else begin
            tx_d    = tx_sh;
            mosi_d  = tx_sh[DATA_WIDTH-1];
            bit_d   = bit_q + 1'b1;
            state_d = LOW;
          end
        end
      end
      HOLD: begin
        if (half_end) begin
          cs_d    = 1'b1;
          dout_d  = rx_q;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        // A held start is taken on the edge ready would return, so
        // back-to-back frames are separated by exactly one gap.
        if (half_end) begin
          if (bus.start) begin
            accept = 1'b1;
          end else begin
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      tx_d    = bus.data_in;
      cs_d    = 1'b0;
      mosi_d  = bus.data_in[DATA_WIDTH-1];
      ready_d = 1'b0;
      bit_d   = '0;
      hcnt_d  = '0;
      state_d = SETUP;
    end
  end

endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver: random frames against a timing/value model
// with a mode-0 slave or loopback on miso.
module tb_spi_master_driver;

  localparam int D  = 8;
  localparam int H  = 2;
  localparam int FR = 2 * H * D + 2 * H;

  logic clk;
  logic rst;

  int n_chk = 0;
  int n_err = 0;

  bit       loop;
  logic [7:0] sbyte;
  int       sidx;
  logic     sclk_prev;

  spi_master_driver_if #(.DATA_WIDTH(D)) ifc ();

  spi_master_driver #(
    .DATA_WIDTH      (D),
    .SCLK_HALFPERIOD (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: first bit valid when cs falls, next bit after each sclk fall.
  always @(ifc.cs or ifc.sclk) begin
    if (ifc.cs) sidx = 0;
    else if (sclk_prev && !ifc.sclk) sidx = sidx + 1;
    sclk_prev = ifc.sclk;
  end

  // miso source: loopback from mosi or the slave byte.
  always_comb begin
    if (loop) ifc.miso = ifc.mosi;
    else if (sidx < D) ifc.miso = sbyte[D-1-sidx];
    else ifc.miso = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int i = 0;
    while (ifc.ready !== 1'b1 && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("rdy_wait", ifc.ready, 1);
  endtask

  task automatic run_frame(input logic [7:0] tx, input logic [7:0] sb,
                           input bit lb, input bit poke);
    int rises = 0;
    int dones = 0;
    int dcyc = -1;
    int rcyc = -1;
    int risebad = 0;
    int csbad = 0;
    logic [7:0] mb = '0;
    logic [7:0] dval = '0;
    logic [7:0] expv;
    logic sp = 1'b0;
    expv = lb ? tx : sb;
    loop = lb;
    sbyte = sb;
    wait_ready();
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.data_in = tx;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.data_in = 8'($urandom);
    chk("cs_t0", ifc.cs, 0);
    for (int c = 1; c <= FR + 3; c++) begin
      if (poke && c == 3) ifc.start = 1'b1;
      @(posedge clk);
      #1;
      if (poke && c == 3) begin
        ifc.start = 1'b0;
        chk("rdy_busy", ifc.ready, 0);
      end
      if (ifc.sclk && !sp) begin
        if (c != H + 2 * H * rises) risebad++;
        rises++;
        mb = {mb[6:0], ifc.mosi};
      end
      sp = ifc.sclk;
      if (c < FR - H && ifc.cs) csbad++;
      if (c >= FR - H && !ifc.cs) csbad++;
      if (ifc.done) begin
        dones++;
        dcyc = c;
        dval = ifc.data_out;
      end
      if (ifc.ready && rcyc < 0) rcyc = c;
    end
    chk("rises", rises, D);
    chk("rise_time", risebad, 0);
    chk("mosi_bits", mb, tx);
    chk("done_cnt", dones, 1);
    chk("done_time", dcyc, FR - H);
    chk("rx_val", dval, expv);
    chk("rdy_time", rcyc, FR);
    chk("cs_shape", csbad, 0);
    chk("dout_hold", ifc.data_out, expv);
    chk("rdy_idle", ifc.ready, 1);
  endtask

  task automatic held_start();
    int rises = 0;
    int dones = 0;
    int cshi = 0;
    logic [15:0] mb = '0;
    logic [7:0] d0 = '0;
    logic [7:0] d1 = '0;
    logic sp = 1'b0;
    loop = 1'b1;
    wait_ready();
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.data_in = 8'h01;
    @(posedge clk);
    #1;
    ifc.data_in = 8'h80;
    for (int c = 1; c <= 2 * FR + 2; c++) begin
      @(posedge clk);
      #1;
      if (c == FR) begin
        ifc.start = 1'b0;
        ifc.data_in = 8'h55;
      end
      if (ifc.sclk && !sp) begin
        rises++;
        mb = {mb[14:0], ifc.mosi};
      end
      sp = ifc.sclk;
      if (c < 2 * FR - H && ifc.cs) cshi++;
      if (ifc.done) begin
        if (dones == 0) d0 = ifc.data_out;
        else d1 = ifc.data_out;
        dones++;
      end
    end
    chk("b2b_rises", rises, 2 * D);
    chk("b2b_mosi", mb, 16'h0180);
    chk("b2b_dones", dones, 2);
    chk("b2b_rx0", d0, 8'h01);
    chk("b2b_rx1", d1, 8'h80);
    chk("b2b_gap", cshi, H);
  endtask

  task automatic rst_mid();
    int dones = 0;
    loop = 1'b0;
    sbyte = 8'($urandom);
    wait_ready();
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.data_in = 8'($urandom);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_cs", ifc.cs, 1);
    chk("rst_sclk", ifc.sclk, 0);
    chk("rst_mosi", ifc.mosi, 0);
    chk("rst_ready", ifc.ready, 1);
    chk("rst_done", ifc.done, 0);
    chk("rst_dout", ifc.data_out, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (ifc.done) dones++;
    end
    chk("rst_nodone", dones, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_dout_held", ifc.data_out, 0);
  endtask

  initial begin
    rst = 1'b1;
    loop = 1'b1;
    sbyte = '0;
    ifc.start = 1'b0;
    ifc.data_in = '0;
    #12;
    chk("reset_cs", ifc.cs, 1);
    chk("reset_sclk", ifc.sclk, 0);
    chk("reset_mosi", ifc.mosi, 0);
    chk("reset_ready", ifc.ready, 1);
    chk("reset_done", ifc.done, 0);
    chk("reset_dout", ifc.data_out, 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(8'hA5, 8'h00, 1'b1, 1'b0);
    run_frame(8'hFF, 8'h3C, 1'b0, 1'b0);
    run_frame(8'h5A, 8'hC3, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    held_start();
    run_frame(8'h12, 8'h9E, 1'b0, 1'b0);
    rst_mid();
    run_frame(8'h81, 8'h7E, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
